// File: rtl/line_flush_buffer.sv
// -----------------------------------------------------------------------------
// line_flush_buffer
//
// Line buffer sitting between a UART receiver and a UART transmitter.
// Received bytes are queued in an internal FIFO. A line is handed to the
// transmitter once a complete line (terminated by EOL_CR or EOL_LF) is held,
// or once MAX_LINE bytes are held without any end-of-line byte. A line that
// reaches MAX_LINE bytes without an end-of-line byte is force-wrapped. When
// APPEND_CRLF is set, a CR/LF pair is generated after the wrap. That pair
// does not pass through the FIFO.
//
// Ports
//   i_clk       clock
//   i_reset_n   asynchronous reset, active low (synchronous release upstream)
//   i_rx_stb    received byte valid, one-cycle pulse
//   i_rx_data   received byte
//   o_tx_stb    transmit request; held with o_tx_data until accepted
//   o_tx_data   byte to transmit (0 when no request is pending)
//   i_tx_busy   transmitter busy; a byte is accepted when o_tx_stb && !busy
//   o_fill      FIFO occupancy, 0 .. 2**LGFLEN
//   o_overflow  sticky flag: a received byte was dropped (cleared by reset)
//   o_flushing  high whenever a line is being sent (state != IDLE)
// -----------------------------------------------------------------------------
module line_flush_buffer #(
   parameter int            BW          = 8,
   parameter int            LGFLEN      = 8,
   parameter int            MAX_LINE    = 80,
   parameter logic [BW-1:0] EOL_CR      = 8'h0d,
   parameter logic [BW-1:0] EOL_LF      = 8'h0a,
   parameter bit            APPEND_CRLF = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_rx_stb,
   input  logic [BW-1:0]     i_rx_data,
   output logic              o_tx_stb,
   output logic [BW-1:0]     o_tx_data,
   input  logic              i_tx_busy,
   output logic [LGFLEN:0]   o_fill,
   output logic              o_overflow,
   output logic              o_flushing
);

   localparam int              DEPTH      = 1 << LGFLEN;
   localparam logic [LGFLEN:0] DEPTH_C    = (LGFLEN+1)'(DEPTH);
   localparam logic [LGFLEN:0] MAX_LINE_C = (LGFLEN+1)'(MAX_LINE);

   generate
      if (MAX_LINE > DEPTH || MAX_LINE == 0) begin : g_bad_max_line
         $error("line_flush_buffer: MAX_LINE must be in 1..2**LGFLEN");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_WRAP_CR,
      S_WRAP_LF
   } state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       mem_q [DEPTH];
   logic [LGFLEN-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LGFLEN:0]     fill_q;
   logic [LGFLEN:0]     eol_pending_q;
   logic [LGFLEN:0]     sent_cnt_q, sent_cnt_d;
   logic [LGFLEN:0]     sent_cnt_inc;
   logic                overflow_q;

   logic [BW-1:0]       head;
   logic                fifo_empty, fifo_full;
   logic                rd_en, wr_en;
   logic                eol_wr, eol_rd, head_is_eol;

   function automatic logic is_eol(input logic [BW-1:0] b);
      return (b == EOL_CR) || (b == EOL_LF);
   endfunction

   assign head         = mem_q[rd_ptr_q];
   assign fifo_empty   = (fill_q == '0);
   assign fifo_full    = (fill_q == DEPTH_C);
   assign head_is_eol  = is_eol(head);
   assign sent_cnt_inc = sent_cnt_q + 1'b1;

   // Only FLUSH drains the FIFO; the wrap bytes are generated locally.
   assign rd_en  = (state_q == S_FLUSH) && !fifo_empty && !i_tx_busy;
   // A full FIFO still takes a byte if a slot frees up in the same cycle.
   assign wr_en  = i_rx_stb && (!fifo_full || rd_en);
   assign eol_wr = wr_en && is_eol(i_rx_data);
   assign eol_rd = rd_en && head_is_eol;

   // FIFO storage: no reset needed, the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_rx_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         eol_pending_q <= '0;
         sent_cnt_q    <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sent_cnt_q <= sent_cnt_d;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   fill_q <= fill_q + 1'b1;
            2'b01:   fill_q <= fill_q - 1'b1;
            default: fill_q <= fill_q;
         endcase
         case ({eol_wr, eol_rd})
            2'b10:   eol_pending_q <= eol_pending_q + 1'b1;
            2'b01:   eol_pending_q <= eol_pending_q - 1'b1;
            default: eol_pending_q <= eol_pending_q;
         endcase
         if (i_rx_stb && !wr_en) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sent_cnt_d = sent_cnt_q;
      o_tx_stb   = 1'b0;
      o_tx_data  = '0;
      case (state_q)
         S_IDLE: begin
            // Either a terminated line is queued somewhere, or the head has
            // enough bytes to force a wrap: in both cases the head line is
            // complete and can be sent without waiting for more input.
            if (eol_pending_q != '0 || fill_q >= MAX_LINE_C) begin
               state_d    = S_FLUSH;
               sent_cnt_d = '0;
            end
         end
         S_FLUSH: begin
            o_tx_stb  = !fifo_empty;
            o_tx_data = fifo_empty ? '0 : head;
            if (rd_en) begin
               sent_cnt_d = sent_cnt_inc;
               if (head_is_eol) begin
                  state_d = S_IDLE;
               end else if (sent_cnt_inc == MAX_LINE_C) begin
                  state_d = APPEND_CRLF ? S_WRAP_CR : S_IDLE;
               end
            end
         end
         S_WRAP_CR: begin
            o_tx_stb  = 1'b1;
            o_tx_data = EOL_CR;
            if (!i_tx_busy) begin
               state_d = S_WRAP_LF;
            end
         end
         S_WRAP_LF: begin
            o_tx_stb  = 1'b1;
            o_tx_data = EOL_LF;
            if (!i_tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_fill     = fill_q;
   assign o_overflow = overflow_q;
   assign o_flushing = (state_q != S_IDLE);

endmodule

// File: tb/tb_line_flush_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for line_flush_buffer (BW=8, LGFLEN=4, MAX_LINE=12, APPEND_CRLF=1).
// The reference model works on byte streams. Every accepted received byte is
// appended to a line. A line is closed by an end-of-line byte. A line is also
// closed after MAX_LINE bytes, and then a CR/LF pair is added to it. Closed
// lines make up the expected transmit stream. The bytes of the open line are
// what stays in the FIFO once everything has drained.
// -----------------------------------------------------------------------------
module tb_line_flush_buffer;

   localparam int LGFLEN   = 4;
   localparam int MAX_LINE = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_stb = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              tx_busy = 1'b0;
   logic              tx_stb;
   logic [7:0]        tx_data;
   logic [LGFLEN:0]   fill;
   logic              overflow;
   logic              flushing;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] line_q[$];

   line_flush_buffer #(
      .BW(8), .LGFLEN(LGFLEN), .MAX_LINE(MAX_LINE),
      .EOL_CR(8'h0d), .EOL_LF(8'h0a), .APPEND_CRLF(1'b1)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_rx_stb(rx_stb), .i_rx_data(rx_data),
      .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
      .o_fill(fill), .o_overflow(overflow), .o_flushing(flushing)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      line_q.push_back(b);
      if (b == 8'h0d || b == 8'h0a) begin
         foreach (line_q[i]) exp_q.push_back(line_q[i]);
         line_q.delete();
      end else if (line_q.size() == MAX_LINE) begin
         foreach (line_q[i]) exp_q.push_back(line_q[i]);
         exp_q.push_back(8'h0d);
         exp_q.push_back(8'h0a);
         line_q.delete();
      end
   endtask

   // Accepted-byte monitor and hold-steady check, sampled on the falling edge.
   logic       hold_prev = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_prev) begin
            chk("hold_stb", 32'(tx_stb), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_stb && !tx_busy) got_q.push_back(tx_data);
      end
      hold_prev <= rst_n && tx_stb && tx_busy;
      prev_data <= tx_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_stb  = 1'b1;
      rx_data = b;
      step();
      rx_stb  = 1'b0;
   endtask

   task automatic send_m(input logic [7:0] b);
      send(b);
      model_push(b);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      rx_stb  = 1'b0;
      tx_busy = 1'b0;
      step();
      step();
      got_q.delete();
      exp_q.delete();
      line_q.delete();
      rst_n = 1'b1;
      step();
   endtask

   task automatic drain(input string tag);
      int i;
      tx_busy = 1'b0;
      for (i = 0; i < 2000 && !(got_q.size() >= exp_q.size() && !flushing); i++) step();
      chk({tag, "_done"}, 32'(got_q.size() >= exp_q.size() && !flushing), 32'd1);
      repeat (3) step();
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         logic [31:0] g;
         g = (k < got_q.size()) ? 32'(got_q[k]) : 32'hdead;
         chk($sformatf("%s_byte%0d", tag, k), g, 32'(exp_q[k]));
      end
      chk({tag, "_fill"}, 32'(fill), 32'(line_q.size()));
      chk({tag, "_flushing"}, 32'(flushing), 32'd0);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] b;

      // Reset state
      step();
      step();
      chk("rst_tx_stb", 32'(tx_stb), 32'd0);
      chk("rst_fill", 32'(fill), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_flushing", 32'(flushing), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: "AB\n", latency of two cycles after the LF strobe
      send_m(8'h41);
      send_m(8'h42);
      send_m(8'h0a);
      chk("t1_lat_k1", 32'(tx_stb), 32'd0);
      step();
      chk("t1_lat_k2", 32'(tx_stb), 32'd1);
      chk("t1_first", 32'(tx_data), 32'h41);
      drain("t1");

      // 2: forced wrap after MAX_LINE bytes with CR/LF appended
      for (int i = 0; i < MAX_LINE + 3; i++) send_m(8'h78);
      drain("t2");
      chk("t2_overflow", 32'(overflow), 32'd0);
      do_reset();

      // 3: "a\rb\n" with the transmitter busy for 20 cycles around each accept
      tx_busy = 1'b1;
      send_m(8'h61);
      send_m(8'h0d);
      send_m(8'h62);
      send_m(8'h0a);
      for (int a = 0; a < 4; a++) begin
         int i;
         tx_busy = 1'b1;
         repeat (20) step();
         n = got_q.size();
         tx_busy = 1'b0;
         for (i = 0; i < 50 && got_q.size() == n; i++) step();
         tx_busy = 1'b1;
         chk($sformatf("t3_accept%0d", a), 32'(got_q.size()), 32'(n + 1));
      end
      drain("t3");

      // 4: stalled transmitter, 17 bytes into a 16-deep FIFO
      tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) send_m(8'h78);
      chk("t4_fill16", 32'(fill), 32'd16);
      chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
      send(8'h78);
      chk("t4_fill_full", 32'(fill), 32'd16);
      chk("t4_overflow", 32'(overflow), 32'd1);

      // 5: full FIFO with a read and a receive in the same cycle
      rx_stb  = 1'b1;
      rx_data = 8'h79;
      tx_busy = 1'b0;
      step();
      rx_stb  = 1'b0;
      tx_busy = 1'b1;
      model_push(8'h79);
      chk("t5_fill", 32'(fill), 32'd16);
      chk("t5_overflow", 32'(overflow), 32'd1);
      drain("t45");
      chk("t45_overflow_sticky", 32'(overflow), 32'd1);
      do_reset();
      chk("t45_overflow_clr", 32'(overflow), 32'd0);

      // 6: reset in the middle of flushing "hello\n"
      send_m(8'h68); send_m(8'h65); send_m(8'h6c);
      send_m(8'h6c); send_m(8'h6f); send_m(8'h0a);
      begin
         int i;
         for (i = 0; i < 200 && got_q.size() < 2; i++) step();
      end
      chk("t6_two_sent", 32'(got_q.size()), 32'd2);
      chk("t6_byte0", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'h68);
      chk("t6_byte1", 32'(got_q.size() > 1 ? got_q[1] : 8'h00), 32'h65);
      rst_n = 1'b0;
      #1;
      chk("t6_stb_drop", 32'(tx_stb), 32'd0);
      chk("t6_flushing", 32'(flushing), 32'd0);
      chk("t6_fill", 32'(fill), 32'd0);
      chk("t6_tx_data", 32'(tx_data), 32'd0);
      do_reset();
      send_m(8'h7a);
      send_m(8'h0a);
      drain("t6");

      // Randomised traffic, throttled so nothing is ever dropped
      do_reset();
      for (int c = 0; c < 600; c++) begin
         tx_busy = ($urandom % 10) < 3;
         if (($urandom % 2) == 1 && fill < 14) begin
            if (($urandom % 8) == 0) b = (($urandom % 2) == 1) ? 8'h0d : 8'h0a;
            else b = 8'($urandom_range(126, 32));
            rx_stb  = 1'b1;
            rx_data = b;
            model_push(b);
         end else begin
            rx_stb = 1'b0;
         end
         step();
      end
      rx_stb = 1'b0;
      drain("rnd");
      chk("rnd_overflow", 32'(overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
